// File: rtl/os_generator.sv
// Ordered-set generator for the Gen1/Gen2 transmit path.
// Emits TS1/TS2/EIOS/FTS/IDLE symbols on every lane as PIPE data/K beats.
module os_generator #(
  parameter int         LANESNUMBER = 16,
  parameter int         PIPEWIDTH   = 8,
  parameter logic [7:0] N_FTS       = 8'd32
) (
  input  logic                             Pclk,
  input  logic                             Reset,
  input  logic [2:0]                       OSType,
  input  logic [1:0]                       LaneNumber,
  input  logic [7:0]                       LinkNumber,
  input  logic [2:0]                       Rate,
  input  logic                             Loopback,
  input  logic                             OSGeneratorStart,
  output logic                             OSGeneratorBusy,
  output logic                             OSGeneratorFinish,
  output logic [LANESNUMBER*PIPEWIDTH-1:0] TxData,
  output logic [LANESNUMBER*PIPEWIDTH/8-1:0] TxDataK,
  output logic                             TxValid
);

  localparam int SPC = PIPEWIDTH / 8;
  localparam int DW  = LANESNUMBER * PIPEWIDTH;
  localparam int KW  = LANESNUMBER * SPC;

  localparam logic [2:0] TS1  = 3'b000;
  localparam logic [2:0] TS2  = 3'b001;
  localparam logic [2:0] EIOS = 3'b010;
  localparam logic [2:0] FTS  = 3'b011;
  localparam logic [2:0] IDL  = 3'b100;

  localparam logic [7:0] COM   = 8'hBC;
  localparam logic [7:0] PAD   = 8'hF7;
  localparam logic [7:0] IDLK  = 8'h7C;
  localparam logic [7:0] FTSK  = 8'h3C;

  typedef enum logic {IDLE_S, SEND_S} state_t;

  state_t      state;
  state_t      nextState;
  logic [4:0]  beatCnt;
  logic [2:0]  typeQ;
  logic [1:0]  laneSelQ;
  logic [7:0]  linkQ;
  logic [2:0]  rateQ;
  logic        loopQ;

  logic        accept;
  logic        lastDone;
  logic        emit;
  logic [2:0]  curType;
  logic [1:0]  curLaneSel;
  logic [7:0]  curLink;
  logic [2:0]  curRate;
  logic        curLoop;
  logic [4:0]  beatIdx;
  logic [DW-1:0] dataD;
  logic [KW-1:0] kD;

  // Beats per ordered set for a given type at this PIPE width.
  function automatic logic [4:0] nBeats(input logic [2:0] t);
    if (t == EIOS || t == FTS) return 5'(4 / SPC);
    return 5'(16 / SPC);
  endfunction

  // Symbol n of an ordered set on a lane, returned as {K, data}.
  function automatic logic [8:0] osSym(
    input logic [2:0] t,
    input logic [7:0] link,
    input logic [1:0] laneSel,
    input logic [2:0] rate,
    input logic       lb,
    input int         lane,
    input int         n
  );
    logic [8:0] s;
    logic [2:0] r;
    logic [7:0] laneId;
    s = 9'h000;
    r = (rate == 3'd0) ? 3'd1 : (rate > 3'd5) ? 3'd5 : rate;
    laneId = (laneSel == 2'b01) ? 8'(lane)
                                : 8'(LANESNUMBER - 1 - lane);
    case (t)
      TS1, TS2: begin
        case (n)
          0: s = {1'b1, COM};
          1: s = (link == 8'h00) ? {1'b1, PAD} : {1'b0, link};
          2: s = (laneSel == 2'b01 || laneSel == 2'b10)
                 ? {1'b0, laneId} : {1'b1, PAD};
          3: s = {1'b0, N_FTS};
          4: s = {1'b0, 2'b00, r >= 3'd5, r >= 3'd4,
                  r >= 3'd3, r >= 3'd2, 2'b10};
          5: s = {1'b0, 5'b00000, lb, 2'b00};
          default: s = {1'b0, (t == TS1) ? 8'h4A : 8'h45};
        endcase
      end
      EIOS: s = (n == 0) ? {1'b1, COM} : {1'b1, IDLK};
      FTS:  s = (n == 0) ? {1'b1, COM} : {1'b1, FTSK};
      default: s = 9'h000;
    endcase
    return s;
  endfunction

  assign accept = (state == IDLE_S) && OSGeneratorStart
                  && (OSType <= IDL);
  assign lastDone = (state == SEND_S)
                    && (beatCnt == nBeats(typeQ));
  assign emit = accept || ((state == SEND_S) && !lastDone);

  // On the accept edge the live inputs feed beat 0; afterwards the latches.
  assign curType    = (state == IDLE_S) ? OSType     : typeQ;
  assign curLaneSel = (state == IDLE_S) ? LaneNumber : laneSelQ;
  assign curLink    = (state == IDLE_S) ? LinkNumber : linkQ;
  assign curRate    = (state == IDLE_S) ? Rate       : rateQ;
  assign curLoop    = (state == IDLE_S) ? Loopback   : loopQ;
  assign beatIdx    = (state == IDLE_S) ? 5'd0       : beatCnt;

  // State register.
  always_ff @(posedge Pclk) begin
    if (!Reset) state <= IDLE_S;
    else        state <= nextState;
  end

  // Next state: accept moves to SEND, the final beat returns to IDLE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE_S:  if (accept)   nextState = SEND_S;
      SEND_S:  if (lastDone) nextState = IDLE_S;
      default: nextState = IDLE_S;
    endcase
  end

  // Request latches and beat counter (counts the next beat to emit).
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      beatCnt  <= 5'd0;
      typeQ    <= 3'd0;
      laneSelQ <= 2'd0;
      linkQ    <= 8'd0;
      rateQ    <= 3'd0;
      loopQ    <= 1'b0;
    end else if (accept) begin
      beatCnt  <= 5'd1;
      typeQ    <= OSType;
      laneSelQ <= LaneNumber;
      linkQ    <= LinkNumber;
      rateQ    <= Rate;
      loopQ    <= Loopback;
    end else if (emit) begin
      beatCnt  <= beatCnt + 5'd1;
    end
  end

  // Next beat contents: all lanes alike except the lane-number symbol.
  always_comb begin
    logic [8:0] sym;
    sym   = 9'h000;
    dataD = '0;
    kD    = '0;
    if (emit) begin
      for (int i = 0; i < LANESNUMBER; i++) begin
        for (int j = 0; j < SPC; j++) begin
          sym = osSym(curType, curLink, curLaneSel, curRate,
                      curLoop, i, int'(beatIdx) * SPC + j);
          dataD[i*PIPEWIDTH + j*8 +: 8] = sym[7:0];
          kD[i*SPC + j] = sym[8];
        end
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      TxData            <= '0;
      TxDataK           <= '0;
      TxValid           <= 1'b0;
      OSGeneratorBusy   <= 1'b0;
      OSGeneratorFinish <= 1'b0;
    end else begin
      TxData            <= dataD;
      TxDataK           <= kD;
      TxValid           <= emit;
      OSGeneratorBusy   <= emit;
      OSGeneratorFinish <= lastDone;
    end
  end

endmodule

// File: tb/tb_os_generator.sv
// Bench for os_generator: three widths in lockstep
// checked against a symbol-table model of the ordered sets.
module tb_os_generator;

  logic        Pclk = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  OSType = 3'd0;
  logic [1:0]  LaneNumber = 2'd0;
  logic [7:0]  LinkNumber = 8'd0;
  logic [2:0]  Rate = 3'd1;
  logic        Loopback = 1'b0;
  logic        Start = 1'b0;

  logic [31:0]  d0;
  logic [3:0]   k0;
  logic [47:0]  d1;
  logic [5:0]   k1;
  logic [127:0] d2;
  logic [15:0]  k2;
  logic [2:0]   vOut, bOut, fOut;
  logic [127:0] dOut [3];
  logic [15:0]  kOut [3];

  logic [127:0] histD [3][18];
  logic [15:0]  histK [3][18];

  int compared = 0;
  int mismatched = 0;

  logic [2:0] rType;
  logic [1:0] rLaneSel;
  logic [7:0] rLink;
  logic [2:0] rRate;
  logic       rLb;

  always #5 Pclk = ~Pclk;

  os_generator #(.LANESNUMBER(4), .PIPEWIDTH(8)) u0 (
    .Pclk(Pclk), .Reset(Reset), .OSType(OSType),
    .LaneNumber(LaneNumber), .LinkNumber(LinkNumber),
    .Rate(Rate), .Loopback(Loopback),
    .OSGeneratorStart(Start), .OSGeneratorBusy(bOut[0]),
    .OSGeneratorFinish(fOut[0]), .TxData(d0),
    .TxDataK(k0), .TxValid(vOut[0]));

  os_generator #(.LANESNUMBER(3), .PIPEWIDTH(16)) u1 (
    .Pclk(Pclk), .Reset(Reset), .OSType(OSType),
    .LaneNumber(LaneNumber), .LinkNumber(LinkNumber),
    .Rate(Rate), .Loopback(Loopback),
    .OSGeneratorStart(Start), .OSGeneratorBusy(bOut[1]),
    .OSGeneratorFinish(fOut[1]), .TxData(d1),
    .TxDataK(k1), .TxValid(vOut[1]));

  os_generator #(.LANESNUMBER(4), .PIPEWIDTH(32)) u2 (
    .Pclk(Pclk), .Reset(Reset), .OSType(OSType),
    .LaneNumber(LaneNumber), .LinkNumber(LinkNumber),
    .Rate(Rate), .Loopback(Loopback),
    .OSGeneratorStart(Start), .OSGeneratorBusy(bOut[2]),
    .OSGeneratorFinish(fOut[2]), .TxData(d2),
    .TxDataK(k2), .TxValid(vOut[2]));

  assign dOut[0] = 128'(d0);
  assign dOut[1] = 128'(d1);
  assign dOut[2] = d2;
  assign kOut[0] = 16'(k0);
  assign kOut[1] = 16'(k1);
  assign kOut[2] = k2;

  function automatic int spcOf(int u);
    return (u == 0) ? 1 : (u == 1) ? 2 : 4;
  endfunction

  function automatic int lanesOf(int u);
    return (u == 1) ? 3 : 4;
  endfunction

  function automatic int beatsOf(int u, logic [2:0] t);
    int s;
    s = (t == 3'd2 || t == 3'd3) ? 4 : 16;
    return s / spcOf(u);
  endfunction

  // Full 16-symbol table of the requested set for one lane.
  function automatic logic [8:0] refSym(int lane, int lanes, int n);
    logic [7:0] body [16];
    logic       kb [16];
    int         r;
    logic [7:0] rid;
    for (int i = 0; i < 16; i++) begin
      body[i] = 8'h00;
      kb[i] = 1'b0;
    end
    case (rType)
      3'd0, 3'd1: begin
        for (int i = 6; i < 16; i++)
          body[i] = (rType == 3'd0) ? 8'h4A : 8'h45;
        body[0] = 8'hBC; kb[0] = 1'b1;
        if (rLink == 8'h00) begin body[1] = 8'hF7; kb[1] = 1'b1; end
        else body[1] = rLink;
        if (rLaneSel == 2'b01) body[2] = 8'(lane);
        else if (rLaneSel == 2'b10) body[2] = 8'(lanes - 1 - lane);
        else begin body[2] = 8'hF7; kb[2] = 1'b1; end
        body[3] = 8'd32;
        r = int'(rRate);
        if (r < 1) r = 1;
        if (r > 5) r = 5;
        rid = 8'h02;
        for (int g = 2; g <= 5; g++) if (r >= g) rid[g] = 1'b1;
        body[4] = rid;
        body[5] = rLb ? 8'h04 : 8'h00;
      end
      3'd2, 3'd3: begin
        body[0] = 8'hBC; kb[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
          body[i] = (rType == 3'd2) ? 8'h7C : 8'h3C;
          kb[i] = 1'b1;
        end
      end
      default: ;
    endcase
    return {kb[n], body[n]};
  endfunction

  task automatic expBeat(input int u, input int c,
                         output logic [127:0] ed,
                         output logic [15:0] ek);
    logic [8:0] s;
    int spc;
    spc = spcOf(u);
    ed = '0;
    ek = '0;
    for (int ln = 0; ln < lanesOf(u); ln++)
      for (int j = 0; j < spc; j++) begin
        s = refSym(ln, lanesOf(u), c * spc + j);
        ed[ln*spc*8 + j*8 +: 8] = s[7:0];
        ek[ln*spc + j] = s[8];
      end
  endtask

  // Issue the request held in rType..rLb and follow all three widths.
  task automatic test_os_request(input int hold);
    logic [127:0] ed;
    logic [15:0]  ek;
    int nb;
    logic expV, expF;
    OSType = rType; LaneNumber = rLaneSel; LinkNumber = rLink;
    Rate = rRate; Loopback = rLb; Start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge Pclk);
      if (c == hold) Start = 1'b0;
      if (c == 1) begin
        OSType = 3'($urandom_range(0, 4));
        LaneNumber = 2'($urandom); LinkNumber = 8'($urandom);
        Rate = 3'($urandom); Loopback = 1'($urandom);
      end
      for (int u = 0; u < 3; u++) begin
        nb = beatsOf(u, rType);
        expV = (c < nb);
        expF = (c == nb);
        if (expV) expBeat(u, c, ed, ek);
        else begin ed = '0; ek = '0; end
        histD[u][c] = dOut[u];
        histK[u][c] = kOut[u];
        compared += 5;
        if (vOut[u] !== expV) begin
          mismatched++;
          $display("FAIL valid u%0d t%0d c%0d: got %b want %b",
                   u, rType, c, vOut[u], expV);
        end
        if (bOut[u] !== expV) begin
          mismatched++;
          $display("FAIL busy u%0d t%0d c%0d: got %b want %b",
                   u, rType, c, bOut[u], expV);
        end
        if (fOut[u] !== expF) begin
          mismatched++;
          $display("FAIL finish u%0d t%0d c%0d: got %b want %b",
                   u, rType, c, fOut[u], expF);
        end
        if (dOut[u] !== ed) begin
          mismatched++;
          $display("FAIL data u%0d t%0d c%0d: got %h want %h",
                   u, rType, c, dOut[u], ed);
        end
        if (kOut[u] !== ek) begin
          mismatched++;
          $display("FAIL datak u%0d t%0d c%0d: got %h want %h",
                   u, rType, c, kOut[u], ek);
        end
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; Start = 1'b1; OSType = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Pclk);
      for (int u = 0; u < 3; u++) begin
        compared++;
        if ({vOut[u], bOut[u], fOut[u]} !== 3'b000
            || dOut[u] !== '0 || kOut[u] !== '0) begin
          mismatched++;
          $display("FAIL reset u%0d c%0d: got v%b b%b f%b d%h want 0",
                   u, c, vOut[u], bOut[u], fOut[u], dOut[u]);
        end
      end
    end
    Start = 1'b0; Reset = 1'b1;
    @(negedge Pclk);
  endtask

  task automatic test_ts1_seq;
    logic [7:0] exp [16];
    rType = 3'd0; rLink = 8'h01; rLaneSel = 2'b01;
    rRate = 3'd1; rLb = 1'b1;
    test_os_request(0);
    exp = '{8'hBC, 8'h01, 8'h02, 8'h20, 8'h02, 8'h04,
            8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A,
            8'h4A, 8'h4A, 8'h4A, 8'h4A};
    for (int b = 0; b < 16; b++) begin
      compared++;
      if (histD[0][b][23:16] !== exp[b]
          || histK[0][b][2] !== (b == 0)) begin
        mismatched++;
        $display("FAIL ts1_lane2 beat%0d: got %h/%b want %h/%b",
                 b, histD[0][b][23:16], histK[0][b][2],
                 exp[b], (b == 0));
      end
    end
  endtask

  task automatic test_ts2_pad;
    rType = 3'd1; rLink = 8'h00; rLaneSel = 2'b00;
    rRate = 3'd5; rLb = 1'b0;
    test_os_request(1);
    for (int ln = 0; ln < 4; ln++) begin
      compared++;
      if (histD[2][0][ln*32 +: 32] !== 32'h20F7F7BC
          || histK[2][0][ln*4 +: 4] !== 4'b0111) begin
        mismatched++;
        $display("FAIL ts2_pad lane%0d: got %h/%b want 20f7f7bc/0111",
                 ln, histD[2][0][ln*32 +: 32], histK[2][0][ln*4 +: 4]);
      end
    end
  endtask

  task automatic test_eios;
    rType = 3'd2; rLink = 8'h05; rLaneSel = 2'b10;
    rRate = 3'd2; rLb = 1'b0;
    test_os_request(1);
    compared++;
    if (histD[2][0][31:0] !== 32'h7C7C7CBC
        || histK[2][0][3:0] !== 4'b1111) begin
      mismatched++;
      $display("FAIL eios32: got %h/%b want 7c7c7cbc/1111",
               histD[2][0][31:0], histK[2][0][3:0]);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 14; n++) begin
      rType = 3'($urandom_range(0, 4));
      rLink = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rLaneSel = 2'($urandom);
      rRate = 3'($urandom);
      rLb = 1'($urandom);
      test_os_request(int'($urandom_range(0, 1)));
    end
  endtask

  // Start held for edges k..k+33: sets repeat with one idle gap.
  task automatic test_back_to_back;
    int nb, p, ph;
    logic expV, expF;
    rType = 3'd4;
    OSType = 3'd4; Start = 1'b1;
    for (int c = 0; c < 38; c++) begin
      @(negedge Pclk);
      if (c == 33) Start = 1'b0;
      for (int u = 0; u < 3; u++) begin
        nb = beatsOf(u, 3'd4);
        p = nb + 1;
        ph = c % p;
        expV = (ph < nb) && (c - ph <= 33);
        expF = (ph == nb) && (c - nb <= 33);
        compared += 3;
        if (vOut[u] !== expV || bOut[u] !== expV) begin
          mismatched++;
          $display("FAIL held_valid u%0d c%0d: got v%b b%b want %b",
                   u, c, vOut[u], bOut[u], expV);
        end
        if (fOut[u] !== expF) begin
          mismatched++;
          $display("FAIL held_finish u%0d c%0d: got %b want %b",
                   u, c, fOut[u], expF);
        end
        if (dOut[u] !== '0 || kOut[u] !== '0) begin
          mismatched++;
          $display("FAIL held_data u%0d c%0d: got %h/%h want 0",
                   u, c, dOut[u], kOut[u]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_and_reserved;
    OSType = 3'd0; LaneNumber = 2'b01; LinkNumber = 8'h07;
    Rate = 3'd3; Loopback = 1'b0; Start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Pclk);
      Start = 1'b0;
    end
    compared++;
    if (vOut[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_beat5 valid: got %b want 1", vOut[0]);
    end
    Reset = 1'b0;
    @(negedge Pclk);
    for (int u = 0; u < 3; u++) begin
      compared++;
      if ({vOut[u], bOut[u], fOut[u]} !== 3'b000
          || dOut[u] !== '0 || kOut[u] !== '0) begin
        mismatched++;
        $display("FAIL mid_reset u%0d: got v%b b%b f%b d%h want 0",
                 u, vOut[u], bOut[u], fOut[u], dOut[u]);
      end
    end
    Reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) OSType = 3'b111;
      if (c == 6) OSType = 3'b101;
      Start = (c >= 3);
      @(negedge Pclk);
      for (int u = 0; u < 3; u++) begin
        compared++;
        if ({vOut[u], bOut[u], fOut[u]} !== 3'b000) begin
          mismatched++;
          $display("FAIL post_reset u%0d c%0d: got v%b b%b f%b want 000",
                   u, c, vOut[u], bOut[u], fOut[u]);
        end
      end
    end
    Start = 1'b0;
    @(negedge Pclk);
  endtask

  initial begin
    test_reset();
    test_ts1_seq();
    test_ts2_pad();
    test_eios();
    test_random();
    test_back_to_back();
    test_reset_mid_and_reserved();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
